// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - register-file write-port arbiter between pipeline writeback and MCU results
// Holds the MCU busy scoreboard, the decode hazard stall and the MCU anti-starvation FSM.
module rf_wb_scheduler #(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int STARVE_LIMIT = 4,
  localparam int AW          = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_we,
  input  logic [AW-1:0]   pipe_waddr,
  input  logic [XLEN-1:0] pipe_wdata,
  input  logic            mcu_issue,
  input  logic [AW-1:0]   mcu_issue_rd,
  input  logic            mcu_valid,
  input  logic [AW-1:0]   mcu_waddr,
  input  logic [XLEN-1:0] mcu_wdata,
  output logic            mcu_ready,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_raddr1,
  input  logic [AW-1:0]   id_raddr2,
  input  logic            id_we,
  input  logic [AW-1:0]   id_waddr,
  output logic            hazard_stall,
  output logic            pipe_hold,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [NREG-1:0] busy_mask
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FORCE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic [NREG-1:0] busy_q, busy_d;

  logic pipe_act, mcu_act, mcu_gnt, pipe_gnt, in_force;

  assign pipe_act = pipe_we & (pipe_waddr != '0);
  assign mcu_act  = mcu_valid & (mcu_waddr != '0);
  assign in_force = (state_q == S_FORCE);
  assign mcu_gnt  = mcu_valid & (!pipe_act | in_force);
  assign pipe_gnt = pipe_act & !in_force;
  assign cnt_inc  = wait_cnt_q + CW'(1);

  // An MCU result for x0 is acknowledged without touching the port.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (pipe_gnt) begin
      rf_we    = 1'b1;
      rf_waddr = pipe_waddr;
      rf_wdata = pipe_wdata;
    end else if (mcu_gnt & mcu_act) begin
      rf_we    = 1'b1;
      rf_waddr = mcu_waddr;
      rf_wdata = mcu_wdata;
    end
  end

  assign mcu_ready = mcu_gnt;
  assign pipe_hold = in_force;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        wait_cnt_d = '0;
        if (mcu_valid & pipe_act) begin
          wait_cnt_d = CW'(1);
          state_d    = (STARVE_LIMIT == 1) ? S_FORCE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!mcu_valid || !pipe_act) begin
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = cnt_inc;
          if (cnt_inc == CW'(STARVE_LIMIT)) state_d = S_FORCE;
        end
      end
      S_FORCE: begin
        state_d    = S_IDLE;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = S_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Set after clear so a same-cycle reissue of the retiring register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (mcu_gnt) busy_d[mcu_waddr] = 1'b0;
    if (mcu_issue && mcu_issue_rd != '0) busy_d[mcu_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign busy_mask = busy_q;

  assign hazard_stall = id_valid &
                        (((id_raddr1 != '0) & busy_q[id_raddr1]) |
                         ((id_raddr2 != '0) & busy_q[id_raddr2]) |
                         (id_we & (id_waddr != '0) & busy_q[id_waddr]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      busy_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb/tb_rf_wb_scheduler.sv - directed self-checking bench for rf_wb_scheduler
// Inputs change 1 time unit after posedge; outputs are sampled 1 unit later.
module tb_rf_wb_scheduler;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        mcu_issue;
  logic [4:0]  mcu_issue_rd;
  logic        mcu_valid;
  logic [4:0]  mcu_waddr;
  logic [31:0] mcu_wdata;
  logic        mcu_ready;
  logic        id_valid;
  logic [4:0]  id_raddr1;
  logic [4:0]  id_raddr2;
  logic        id_we;
  logic [4:0]  id_waddr;
  logic        hazard_stall;
  logic        pipe_hold;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;

  int n_tests;
  int n_fail;

  rf_wb_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_we      (pipe_we),
    .pipe_waddr   (pipe_waddr),
    .pipe_wdata   (pipe_wdata),
    .mcu_issue    (mcu_issue),
    .mcu_issue_rd (mcu_issue_rd),
    .mcu_valid    (mcu_valid),
    .mcu_waddr    (mcu_waddr),
    .mcu_wdata    (mcu_wdata),
    .mcu_ready    (mcu_ready),
    .id_valid     (id_valid),
    .id_raddr1    (id_raddr1),
    .id_raddr2    (id_raddr2),
    .id_we        (id_we),
    .id_waddr     (id_waddr),
    .hazard_stall (hazard_stall),
    .pipe_hold    (pipe_hold),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .busy_mask    (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    mcu_issue = 1'b0; mcu_issue_rd = '0;
    mcu_valid = 1'b0; mcu_waddr = '0; mcu_wdata = '0;
    id_valid = 1'b0; id_raddr1 = '0; id_raddr2 = '0; id_we = 1'b0; id_waddr = '0;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle_inputs();
    mcu_issue = 1'b1; mcu_issue_rd = rd;
    tick();
    mcu_issue = 1'b0; mcu_issue_rd = '0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("reset_busy", 64'(busy_mask), 64'h0);
    chk("reset_rf_we", 64'(rf_we), 64'h0);
    chk("reset_hold", 64'(pipe_hold), 64'h0);
    tick();

    // 1: reset while in WAIT with cnt=2
    issue(5'd3);
    mcu_valid = 1'b1; mcu_waddr = 5'd3; mcu_wdata = 32'h33;
    pipe_we = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h11;
    settle();
    chk("t1_pipe_wins", 64'(mcu_ready), 64'h0);
    tick(); tick();
    chk("t1_busy_pre", 64'(busy_mask), 64'h8);
    idle_inputs();
    id_valid = 1'b1; id_raddr1 = 5'd3;
    rst = 1'b1;
    settle();
    chk("t1_busy", 64'(busy_mask), 64'h0);
    chk("t1_rf_we", 64'(rf_we), 64'h0);
    chk("t1_ready", 64'(mcu_ready), 64'h0);
    chk("t1_hold", 64'(pipe_hold), 64'h0);
    chk("t1_stall", 64'(hazard_stall), 64'h0);
    chk("t1_waddr", 64'(rf_waddr), 64'h0);
    chk("t1_wdata", 64'(rf_wdata), 64'h0);
    tick();
    rst = 1'b0;
    tick();

    // 2: MCU write with idle pipeline
    issue(5'd7);
    mcu_valid = 1'b1; mcu_waddr = 5'd7; mcu_wdata = 32'h55;
    settle();
    chk("t2_rf_we", 64'(rf_we), 64'h1);
    chk("t2_waddr", 64'(rf_waddr), 64'h7);
    chk("t2_wdata", 64'(rf_wdata), 64'h55);
    chk("t2_ready", 64'(mcu_ready), 64'h1);
    chk("t2_busy_pre", 64'(busy_mask), 64'h80);
    tick();
    mcu_valid = 1'b0;
    settle();
    chk("t2_busy_post", 64'(busy_mask), 64'h0);

    // 3: starvation bound, pipe wins 4 cycles then forced MCU slot
    issue(5'd8);
    mcu_valid = 1'b1; mcu_waddr = 5'd8; mcu_wdata = 32'hAB;
    for (int k = 1; k <= 4; k++) begin
      pipe_we = 1'b1; pipe_waddr = 5'(k + 10); pipe_wdata = 32'h100 + 32'(k);
      settle();
      chk("t3_pipe_waddr", 64'(rf_waddr), 64'(k + 10));
      chk("t3_pipe_wdata", 64'(rf_wdata), 64'h100 + 64'(k));
      chk("t3_no_ready", 64'(mcu_ready), 64'h0);
      chk("t3_no_hold", 64'(pipe_hold), 64'h0);
      tick();
    end
    pipe_we = 1'b1; pipe_waddr = 5'd15; pipe_wdata = 32'h105;
    settle();
    chk("t3_force_hold", 64'(pipe_hold), 64'h1);
    chk("t3_force_ready", 64'(mcu_ready), 64'h1);
    chk("t3_force_we", 64'(rf_we), 64'h1);
    chk("t3_force_waddr", 64'(rf_waddr), 64'h8);
    chk("t3_force_wdata", 64'(rf_wdata), 64'hAB);
    tick();
    mcu_valid = 1'b0;
    settle();
    chk("t3_replay_hold", 64'(pipe_hold), 64'h0);
    chk("t3_replay_waddr", 64'(rf_waddr), 64'hF);
    chk("t3_replay_wdata", 64'(rf_wdata), 64'h105);
    chk("t3_busy", 64'(busy_mask), 64'h0);
    tick();

    // 4: RAW stall held through the clearing write, released after
    issue(5'd5);
    id_valid = 1'b1; id_raddr2 = 5'd5;
    settle();
    chk("t4_stall", 64'(hazard_stall), 64'h1);
    tick();
    mcu_valid = 1'b1; mcu_waddr = 5'd5; mcu_wdata = 32'h5;
    settle();
    chk("t4_stall_clearing", 64'(hazard_stall), 64'h1);
    tick();
    mcu_valid = 1'b0;
    settle();
    chk("t4_release", 64'(hazard_stall), 64'h0);

    // 5: same-cycle issue and retire of x9, set wins
    issue(5'd9);
    mcu_valid = 1'b1; mcu_waddr = 5'd9; mcu_wdata = 32'h99;
    mcu_issue = 1'b1; mcu_issue_rd = 5'd9;
    tick();
    idle_inputs();
    id_valid = 1'b1; id_we = 1'b1; id_waddr = 5'd9;
    settle();
    chk("t5_busy", 64'(busy_mask), 64'h200);
    chk("t5_waw_stall", 64'(hazard_stall), 64'h1);
    idle_inputs();
    mcu_valid = 1'b1; mcu_waddr = 5'd9;
    tick();
    mcu_valid = 1'b0;
    settle();
    chk("t5_busy_clear", 64'(busy_mask), 64'h0);

    // 6: pipeline x0 write never blocks the MCU or reaches the port
    issue(5'd12);
    mcu_valid = 1'b1; mcu_waddr = 5'd12; mcu_wdata = 32'h77;
    pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'hDEAD;
    settle();
    chk("t6_ready", 64'(mcu_ready), 64'h1);
    chk("t6_waddr", 64'(rf_waddr), 64'hC);
    chk("t6_wdata", 64'(rf_wdata), 64'h77);
    tick();
    idle_inputs();
    mcu_valid = 1'b1; mcu_waddr = 5'd0; mcu_wdata = 32'h1;
    settle();
    chk("t6_x0_ready", 64'(mcu_ready), 64'h1);
    chk("t6_x0_we", 64'(rf_we), 64'h0);
    tick();
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
